ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 32 +++
 rtl/ram_arbiter_if.sv | 54 +++++
 rtl/ram_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module      : ram_arbiter_pkg
// Description : Shared widths, FSM state encoding and requester indices for
//               the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEMORY_WORD_SIZE
`define MEMORY_WORD_SIZE 8
`endif
`ifndef RAM_SIZE
`define RAM_SIZE 8
`endif

package ram_arbiter_pkg;

    localparam int WORD_W = `MEMORY_WORD_SIZE;
    localparam int ADDR_W = `RAM_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module      : ram_arbiter_if
// Description : Requester handshakes plus RAM-side bus of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int DW = WORD_W,
    parameter int AW = ADDR_W
);
    logic          m0_req, m0_we, m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req, m1_we, m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    modport ram (
        input  ram_we, ram_addr, ram_din,
        output ram_dout
    );

endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module      : ram_arbiter
// Description : Two-requester arbiter for a single-port synchronous RAM with
//               lock-based ownership. Define RAM_ARB_RR_EN for round-robin
//               contention handling; otherwise requester 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MEMORY_WORD_SIZE
`define MEMORY_WORD_SIZE 8
`endif
`ifndef RAM_SIZE
`define RAM_SIZE 8
`endif

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int MEMORY_WORD_SIZE = `MEMORY_WORD_SIZE,
    parameter int RAM_SIZE         = `RAM_SIZE
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    ram_arbiter_if.slave bus
);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic                        w_gnt0;
    logic                        w_gnt1;
    logic                        w_pick1;
    logic [RAM_SIZE-1:0]         r_addr;
    logic [MEMORY_WORD_SIZE-1:0] r_din;
    logic                        r_rv0;
    logic                        r_rv1;

`ifdef RAM_ARB_RR_EN
    // Requester that wins the next contention in IDLE.
    logic r_rr_pri;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_pri <= REQ_M0;
        end else if (w_gnt0) begin
            r_rr_pri <= REQ_M1;
        end else if (w_gnt1) begin
            r_rr_pri <= REQ_M0;
        end
    end

    assign w_pick1 = (r_rr_pri == REQ_M1);
`else
    assign w_pick1 = 1'b0;
`endif

    // Grants are masked during reset so nothing reaches the RAM.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.m0_req && bus.m1_req) begin
                        w_gnt0 = !w_pick1;
                        w_gnt1 = w_pick1;
                    end else begin
                        w_gnt0 = bus.m0_req;
                        w_gnt1 = bus.m1_req;
                    end
                    if (w_gnt0 && bus.m0_lock) begin
                        w_state_nxt = ST_OWN0;
                    end else if (w_gnt1 && bus.m1_lock) begin
                        w_state_nxt = ST_OWN1;
                    end
                end
                ST_OWN0: begin
                    w_gnt0 = bus.m0_req;
                    if (!bus.m0_lock) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_OWN1: begin
                    w_gnt1 = bus.m1_req;
                    if (!bus.m1_lock) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_din   <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt0) begin
                r_addr <= bus.m0_addr;
                r_din  <= bus.m0_wdata;
            end else if (w_gnt1) begin
                r_addr <= bus.m1_addr;
                r_din  <= bus.m1_wdata;
            end
            r_rv0 <= w_gnt0 && !bus.m0_we;
            r_rv1 <= w_gnt1 && !bus.m1_we;
        end
    end

    assign bus.m0_gnt    = w_gnt0;
    assign bus.m1_gnt    = w_gnt1;
    assign bus.ram_we    = (w_gnt0 && bus.m0_we) || (w_gnt1 && bus.m1_we);
    // Idle cycles keep presenting the last granted address/data.
    assign bus.ram_addr  = w_gnt0 ? bus.m0_addr  : (w_gnt1 ? bus.m1_addr  : r_addr);
    assign bus.ram_din   = w_gnt0 ? bus.m0_wdata : (w_gnt1 ? bus.m1_wdata : r_din);
    assign bus.m0_rvalid = r_rv0;
    assign bus.m1_rvalid = r_rv1;
    assign bus.m0_rdata  = r_rv0 ? bus.ram_dout : '0;
    assign bus.m1_rdata  = r_rv1 ? bus.ram_dout : '0;

endmodule

`default_nettype wire
